// File: rtl/sum_series_pkg.sv
// Shared definitions for the sum-series scheduler.
//   WIDTH      default operand/result width
//   REQ0/REQ1  requester index constants
//   state_t    scheduler FSM encoding
//   req_onehot maps a requester index to its one-hot request/ack bit
package sum_series_pkg;

  localparam int unsigned WIDTH = 8;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    ACCUM = 2'b10,
    DONE  = 2'b11
  } state_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sum_series_accum.sv
// Accumulate datapath for the sum-series engine: R += C, C += 1.
// Ports:
//   Clk, Rst_n  clock, asynchronous active-low reset
//   ClearAcc    load R=0, C=1 (start of a job)
//   Step        perform one addition and advance the counter
//   Nreg        operand of the job being served
//   Acc         current running sum R (mod 2^WIDTH)
//   CleN        high while C <= Nreg, i.e. more terms remain to add
module sum_series_accum
  import sum_series_pkg::*;
#(
  parameter int unsigned WIDTH = sum_series_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ClearAcc,
  input  logic             Step,
  input  logic [WIDTH-1:0] Nreg,
  output logic [WIDTH-1:0] Acc,
  output logic             CleN
);

  // C carries one extra bit so that N = 2^WIDTH-1 still reaches C > N.
  logic [WIDTH:0]   cnt;
  logic [WIDTH-1:0] r;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r   <= '0;
      cnt <= '0;
    end else if (ClearAcc) begin
      r   <= '0;
      cnt <= (WIDTH+1)'(1);
    end else if (Step) begin
      r   <= r + cnt[WIDTH-1:0];
      cnt <= cnt + (WIDTH+1)'(1);
    end
  end

  always_comb begin
    CleN = (cnt <= {1'b0, Nreg});
    Acc  = r;
  end

endmodule

// File: rtl/sum_series_sched.sv
// Shared-resource scheduler for the sum-series engine. Two requesters
// present an operand N; the winner of a round-robin arbitration gets
// 1+2+...+N (mod 2^WIDTH) computed on a single shared accumulator.
// Ports:
//   Clk, Rst_n  clock, asynchronous active-low reset
//   Req[1:0]    request levels, held with operand stable until Ack
//   N0, N1      operands of requester 0 / 1
//   Ack[1:0]    one-cycle pulse: request accepted, operand captured
//   Done[1:0]   one-cycle pulse to the owner; Result valid
//   Result      last completed sum, held until the next Done
//   Busy        high whenever the scheduler is not idle
//   Owner       index of the requester currently being served
module sum_series_sched
  import sum_series_pkg::*;
#(
  parameter int unsigned WIDTH = sum_series_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [1:0]       Req,
  input  logic [WIDTH-1:0] N0,
  input  logic [WIDTH-1:0] N1,
  output logic [1:0]       Ack,
  output logic [1:0]       Done,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Owner
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] nreg;
  logic             last;
  logic             win;
  logic             clear_acc;
  logic             step;
  logic             cle_n;
  logic [WIDTH-1:0] acc;

  // Arbiter: a lone requester wins; on a tie the one not served last wins.
  // last resets to 1 so requester 0 takes the first tie.
  always_comb begin
    win = 1'(REQ0);
    if (Req == 2'b11) begin
      win = ~last;
    end else if (Req[REQ1]) begin
      win = 1'(REQ1);
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|Req) state_nxt = LOAD;
      LOAD:    state_nxt = ACCUM;
      ACCUM:   if (!cle_n) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore-decoded outputs and datapath controls
  always_comb begin
    Ack       = '0;
    Done      = '0;
    Busy      = (state != IDLE);
    clear_acc = (state == LOAD);
    step      = (state == ACCUM) && cle_n;
    if (state == LOAD) Ack  = req_onehot(Owner);
    if (state == DONE) Done = req_onehot(Owner);
  end

  // Job registers: operand/owner captured on acceptance, result on exit
  // from ACCUM, round-robin pointer updated when the job retires.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      nreg   <= '0;
      Owner  <= 1'b0;
      Result <= '0;
      last   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (|Req) begin
            nreg  <= win ? N1 : N0;
            Owner <= win;
          end
        end
        ACCUM: begin
          if (!cle_n) Result <= acc;
        end
        DONE: begin
          last <= Owner;
        end
        default: ;
      endcase
    end
  end

  sum_series_accum #(
    .WIDTH (WIDTH)
  ) u_accum (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .ClearAcc (clear_acc),
    .Step     (step),
    .Nreg     (nreg),
    .Acc      (acc),
    .CleN     (cle_n)
  );

endmodule

// File: tb/tb_sum_series_sched.sv
// Directed + randomized bench for sum_series_sched. Expected sums come from
// the closed form N(N+1)/2 mod 256; expected winners from the round-robin rule.
module tb_sum_series_sched;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] Req;
  logic [7:0] N0;
  logic [7:0] N1;
  logic [1:0] Ack;
  logic [1:0] Done;
  logic [7:0] Result;
  logic       Busy;
  logic       Owner;

  int checks = 0;
  int errors = 0;
  int model_last;

  always #5 Clk = ~Clk;

  sum_series_sched #(
    .WIDTH (8)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Req    (Req),
    .N0     (N0),
    .N1     (N1),
    .Ack    (Ack),
    .Done   (Done),
    .Result (Result),
    .Busy   (Busy),
    .Owner  (Owner)
  );

  function automatic int ref_sum(input int n);
    return (n * (n + 1) / 2) % 256;
  endfunction

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    if (r[1]) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_ack(input int exp_w, input bit drop);
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Ack !== 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) return;
    check("ack_val", 32'(Ack), 32'(onehot(exp_w)));
    check("ack_owner", 32'(Owner), 32'(exp_w));
    check("ack_busy", 32'(Busy), 32'd1);
    if (drop) Req[exp_w] = 1'b0;
  endtask

  // pre = cycles already elapsed since the Ack cycle
  task automatic wait_done(input int exp_w, input int exp_n, input int pre);
    logic [7:0] prev = Result;
    bit got = 1'b0;
    bit stray = 1'b0;
    bit moved = 1'b0;
    int lat = 0;
    for (int k = 1; k <= exp_n + 10; k++) begin
      tick();
      if (Done !== 2'b00) begin
        got = 1'b1;
        lat = k + pre;
        break;
      end
      if (Ack !== 2'b00) stray = 1'b1;
      if (Result !== prev) moved = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    if (!got) return;
    check("done_latency", 32'(lat), 32'(exp_n + 2));
    check("done_val", 32'(Done), 32'(onehot(exp_w)));
    check("done_result", 32'(Result), 32'(ref_sum(exp_n)));
    check("no_ack_while_busy", 32'(stray), 32'd0);
    check("result_held", 32'(moved), 32'd0);
    model_last = exp_w;
    tick();
    check("idle_after_done", 32'(Busy), 32'd0);
    check("done_one_cycle", 32'(Done), 32'd0);
  endtask

  task automatic run_job(input int exp_w, input int exp_n, input bit drop);
    wait_ack(exp_w, drop);
    wait_done(exp_w, exp_n, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    Rst_n = 1'b0;
    Req   = 2'b00;
    N0    = '0;
    N1    = '0;
    #2;
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_owner", 32'(Owner), 32'd0);
    tick();
    tick();
    Rst_n = 1'b1;
    model_last = 1;

    // Single request, N0=4 -> 0x0A
    N0  = 8'd4;
    Req = 2'b01;
    run_job(pick(Req, model_last), 4, 1'b1);

    // Boundary operands on requester 1
    N1  = 8'd0;
    Req = 2'b10;
    run_job(pick(Req, model_last), 0, 1'b1);
    N1  = 8'd255;
    Req = 2'b10;
    run_job(pick(Req, model_last), 255, 1'b1);

    // Simultaneous requests straight after reset: requester 0 first
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    model_last = 1;
    N0  = 8'd3;
    N1  = 8'd23;
    Req = 2'b11;
    run_job(0, 3, 1'b1);
    run_job(1, 23, 1'b1);

    // Fairness with both requests held continuously
    N0  = 8'd2;
    N1  = 8'd2;
    Req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      w = pick(Req, model_last);
      check("fair_alternate", 32'(w), 32'(j % 2));
      run_job(w, 2, 1'b0);
    end
    Req = 2'b00;
    tick();

    // Late arrival of requester 1 while requester 0 accumulates
    N0  = 8'd10;
    Req = 2'b01;
    wait_ack(0, 1'b1);
    tick();
    tick();
    tick();
    N1     = 8'd5;
    Req[1] = 1'b1;
    wait_done(0, 10, 3);
    run_job(pick(Req, model_last), 5, 1'b1);

    // Reset in the middle of ACCUM; held request is re-arbitrated
    N0  = 8'd50;
    Req = 2'b01;
    wait_ack(0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    Rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(Ack), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_result", 32'(Result), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_owner", 32'(Owner), 32'd0);
    tick();
    tick();
    check("midrst_no_done", 32'(Done), 32'd0);
    Rst_n = 1'b1;
    model_last = 1;
    run_job(pick(Req, model_last), 50, 1'b1);

    // Randomized traffic; pending requests keep their operand until served
    for (int r = 0; r < 10; r++) begin
      if (!Req[0] && $urandom_range(1, 0) == 1) begin
        N0     = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 60));
        Req[0] = 1'b1;
      end
      if (!Req[1] && $urandom_range(1, 0) == 1) begin
        N1     = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 60));
        Req[1] = 1'b1;
      end
      if (Req == 2'b00) begin
        N0     = 8'($urandom_range(0, 60));
        Req[0] = 1'b1;
      end
      w = pick(Req, model_last);
      run_job(w, (w == 1) ? int'(N1) : int'(N0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_series_sched.md
# sum_series_sched

Shared-resource scheduler for the sum-series engine. Two requesters each present an operand N. The block arbitrates round-robin between them, sequences an embedded accumulate datapath to compute 1+2+…+N (mod 2^WIDTH), and returns the result to the winning requester with a one-cycle Done pulse. It replaces per-requester hardwired sequencers so one adder/counter/register set serves both clients.

## Interface
- WIDTH, 8, operand/result width; the internal counter is WIDTH+1 bits.
- Clk  input  1  clock; all state updates on posedge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Req  input  2  per-requester request level; Req[i] is held with N_i stable until Ack[i].
- N0  input  WIDTH  operand of requester 0.
- N1  input  WIDTH  operand of requester 1.
- Ack  output  2  one-cycle pulse; request accepted and operand captured.
- Done  output  2  one-cycle pulse to the owner; Result is valid in that cycle.
- Result  output  WIDTH  last completed sum; held until the next Done.
- Busy  output  1  high whenever state != IDLE.
- Owner  output  1  index of the requester being served; meaningful while Busy.

## Operation
- States: IDLE, LOAD, ACCUM, DONE. All outputs are registered or Moore-decoded from state. No combinational path runs from Req to Ack/Done.
- Reset values:
  - state=IDLE, Ack=0, Done=0, Result=0, Busy=0, Owner=0.
  - Internal Nreg=0, R=0, C=0.
  - Last=1, so requester 0 wins the first tie.
- IDLE:
  - If Req==0, stay.
  - Otherwise pick a winner W. If only one requester is active, it wins. If both are active, W = ~Last.
  - Capture Nreg <= N_W and Owner <= W, then go to LOAD.
- LOAD:
  - Ack[Owner]=1 for this cycle only.
  - R <= 0, C <= 1. Go to ACCUM.
- ACCUM:
  - If C <= {1'b0,Nreg}: R <= R + C[WIDTH-1:0] (wraps mod 2^WIDTH), C <= C+1, stay.
  - Else: Result <= R, go to DONE.
- DONE:
  - Done[Owner]=1 for this cycle only.
  - Last <= Owner. Go to IDLE.
- Width rule: C is WIDTH+1 bits, so N=2^WIDTH-1 terminates. Sum bits above WIDTH are discarded.
- Requests are sampled only in IDLE. A Req held or raised while Busy waits.
- A requester whose Req stays high after Done is treated as a new request. Round-robin still applies, so a waiting other requester is served first.
- A Req dropped before Ack is simply never served; no error is flagged.
- If Rst_n is asserted mid-operation, everything returns to reset values immediately. The in-flight request gets no Done. If its Req is still high after Rst_n deasserts, it is re-arbitrated as a fresh request.

## Timing
- Edge e0 is the IDLE edge that samples Req.
  - Ack is high during the cycle after e0 (LOAD).
  - The ACCUM entry edge is e1.
  - Additions occur at e2..e(N+1).
  - The exit check is at e(N+2), after which Done is high for one cycle.
  - IDLE is re-entered at e(N+3). The earliest next sampling edge is e(N+4).
- Ack-to-Done latency is N+2 cycles. N=0 gives Done 2 cycles after Ack.
- Result changes only at the edge that enters DONE and is stable from Done onward.
- Ack and Done are never high in the same cycle. At most one bit of each is set.

## Structure
- Shared package sum_series_pkg:
  - state encoding: IDLE=2'b00, LOAD=2'b01, ACCUM=2'b10, DONE=2'b11;
  - default WIDTH=8;
  - requester index constants REQ0=0, REQ1=1.
- Sub-module sum_series_accum:
  - contains the R register, the WIDTH+1 counter C, the adder and the C<=Nreg comparator;
  - control inputs ClearAcc, Step; status output CleN.
- The top level holds only the FSM, the arbiter (Last), and the Nreg/Owner/Result registers.

## Test plan
- Reset then single request: Req=2'b01, N0=4 -> Ack=2'b01 one cycle; Done=2'b01 6 cycles after Ack; Result=8'h0A; Busy low the following cycle.
- N=0 and N=255 on requester 1 -> Result=8'h00 with Done 2 cycles after Ack; Result=8'h80 with Done 257 cycles after Ack; no hang.
- Simultaneous Req=2'b11 from reset, N0=3, N1=23 -> requester 0 is served first (Result=8'h06); then requester 1 (Result=8'h14); Ack order 01 then 10.
- Fairness: hold Req=2'b11 continuously with N0=N1=2 for four jobs -> Ack alternates 01,10,01,10; each Done carries Result=8'h03.
- Late arrival: Req0 served with N0=10; Req1 raised mid-ACCUM with N1=5 -> no Ack[1] until Busy drops; then Ack[1] and Result=8'h0F; the earlier Result=8'h37 is held until that Done.
- Reset mid-ACCUM: N0=50, Rst_n pulsed low 10 cycles after Ack -> outputs zero immediately with no Done; Req0 still high re-arbitrates and completes with Result=8'hFB (1275 mod 256).
